// File: rtl/pio_cmd_sequencer.sv
// HPS PIO command sequencer: toggle-handshaked command word in,
// valid/ready issue to the datapath, result and status words back out.
module pio_cmd_sequencer #(
  parameter int NUM_OPS        = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMER_W        = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] hps_cmd_word,
  output logic [31:0] status_word,
  output logic [31:0] result_word,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [3:0]  cmd_opcode,
  output logic [26:0] cmd_payload,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_error,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  localparam logic [TIMER_W-1:0] TMAX =
    TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] NOPS = 32'(NUM_OPS);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  state_e state_q, state_d;

  logic [31:0]        cmd_q;
  logic [3:0]         op_q, op_d;
  logic [26:0]        pl_q, pl_d;
  logic [31:0]        res_q, res_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               to_q, to_d;
  logic               il_q, il_d;
  logic               er_q, er_d;
  logic [3:0]         last_q, last_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [TIMER_W-1:0] tmr_q, tmr_d;

  logic expire;
  logic op_bad;

  // Timer reaches its last permitted cycle; the opcode is out of range.
  always_comb begin
    expire = TMO_EN && (tmr_q == TMAX);
    op_bad = {28'd0, cmd_q[30:27]} >= NOPS;
  end

  // Next-state and datapath handshake decisions.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    pl_d      = pl_q;
    res_d     = res_q;
    ack_d     = ack_q;
    busy_d    = busy_q;
    to_d      = to_q;
    il_d      = il_q;
    er_d      = er_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    cmd_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_q[31] != ack_q) begin
          op_d   = cmd_q[30:27];
          pl_d   = cmd_q[26:0];
          to_d   = 1'b0;
          il_d   = 1'b0;
          er_d   = 1'b0;
          busy_d = 1'b1;
          tmr_d  = '0;
          if (op_bad) begin
            il_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cmd_valid = !expire;
        tmr_d     = tmr_q + TIMER_W'(1);
        if (expire) begin
          to_d    = 1'b1;
          res_d   = '1;
          state_d = DONE;
        end else if (cmd_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        tmr_d = tmr_q + TIMER_W'(1);
        if (rsp_valid) begin
          res_d   = rsp_data;
          er_d    = rsp_error;
          state_d = DONE;
        end else if (expire) begin
          to_d    = 1'b1;
          res_d   = '1;
          state_d = DONE;
        end
      end
      DONE: begin
        ack_d   = cmd_q[31];
        last_d  = op_q;
        cnt_d   = cnt_q + 8'd1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and register update; the command word is sampled once here.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      op_q    <= '0;
      pl_q    <= '0;
      res_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      il_q    <= 1'b0;
      er_q    <= 1'b0;
      last_q  <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= hps_cmd_word;
      op_q    <= op_d;
      pl_q    <= pl_d;
      res_q   <= res_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      il_q    <= il_d;
      er_q    <= er_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end

  // Output packing.
  always_comb begin
    status_word = {ack_q, busy_q, to_q, il_q, er_q,
                   last_q, cnt_q, 15'd0};
    result_word = res_q;
    cmd_opcode  = op_q;
    cmd_payload = pl_q;
    busy        = busy_q;
  end

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// Bench for pio_cmd_sequencer: transaction-level outcome model
// plus a per-cycle compare process.
module tb_pio_cmd_sequencer;

  localparam int NOPS = 8;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] hps_cmd_word;
  logic [31:0] status_word;
  logic [31:0] result_word;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [26:0] cmd_payload;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        busy;

  pio_cmd_sequencer #(
    .NUM_OPS(NOPS),
    .TIMEOUT_CYCLES(TMO),
    .TIMER_W(16)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .hps_cmd_word(hps_cmd_word),
    .status_word(status_word),
    .result_word(result_word),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode),
    .cmd_payload(cmd_payload),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_error(rsp_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  bit          m_ack, m_to, m_il, m_er;
  logic [3:0]  m_last, m_op;
  logic [7:0]  m_cnt;
  logic [26:0] m_pl;
  logic [31:0] m_res;
  bit          req;
  bit          mon_en = 1'b0;
  int          vcnt = 0;

  function automatic logic [31:0] exp_status();
    return {m_ack, 1'b0, m_to, m_il, m_er, m_last, m_cnt, 15'd0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ack = 0; m_to = 0; m_il = 0; m_er = 0;
    m_last = '0; m_cnt = '0; m_res = '0;
    m_op = '0; m_pl = '0;
  endtask

  // Compare process: every cycle while monitoring is enabled.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cmd_valid) begin
        vcnt++;
        chk("op_stable", 32'(cmd_opcode), 32'(m_op));
        chk("payload_stable", 32'(cmd_payload), 32'(m_pl));
      end
      chk1("busy_mirror", busy, status_word[30]);
      if (!busy) begin
        chk("status", status_word, exp_status());
        chk("result", result_word, m_res);
        chk1("idle_valid", cmd_valid, 1'b0);
      end
    end
  end

  // One HPS command. Datapath raises ready r cycles after ISSUE entry
  // and answers d cycles after the accept (d=0: never answers).
  // Outcome is derived from the timing rules, not from the DUT.
  task automatic run_cmd(input logic [3:0] op, input logic [26:0] pl,
                         input int r, input int d,
                         input logic [31:0] rd, input logic re,
                         input bit spur, input bit tgl);
    int k;
    int ev_valid, ev_exit;
    req = ~req;
    hps_cmd_word = {req, op, pl};
    m_op = op;
    m_pl = pl;
    vcnt = 0;
    tick();
    tick();
    if (int'(op) < NOPS) chk1("valid_latency", cmd_valid, 1'b1);
    else chk1("illegal_no_valid", cmd_valid, 1'b0);
    k = 0;
    while (busy === 1'b1 && k < 64) begin
      cmd_ready = (k >= r);
      rsp_valid = (d > 0 && k == r + d) || (spur && k == 0 && r > 0);
      rsp_data  = (k == r + d) ? rd : 32'hDEAD_0000;
      rsp_error = re && (k == r + d);
      if (tgl && (k == 1 || k == 3)) begin
        req = ~req;
        hps_cmd_word[31] = req;
      end
      tick();
      k++;
    end
    cmd_ready = 0; rsp_valid = 0; rsp_error = 0; rsp_data = '0;
    if (int'(op) >= NOPS) begin
      ev_valid = 0; ev_exit = 1;
      m_il = 1; m_to = 0; m_er = 0;
    end else if (r >= TMO - 1) begin
      ev_valid = TMO - 1; ev_exit = TMO + 1;
      m_il = 0; m_to = 1; m_er = 0; m_res = '1;
    end else if (d > 0 && r + d <= TMO - 1) begin
      ev_valid = r + 1; ev_exit = r + d + 2;
      m_il = 0; m_to = 0; m_er = re; m_res = rd;
    end else begin
      ev_valid = r + 1; ev_exit = TMO + 1;
      m_il = 0; m_to = 1; m_er = 0; m_res = '1;
    end
    m_ack  = req;
    m_last = op;
    m_cnt  = m_cnt + 8'd1;
    chki("valid_cycles", vcnt, ev_valid);
    chki("done_cycle", k, ev_exit);
  endtask

  initial begin
    rst_n = 0;
    hps_cmd_word = '0;
    cmd_ready = 0; rsp_valid = 0; rsp_data = '0; rsp_error = 0;
    req = 0;
    model_reset();
    repeat (3) tick();
    chk("rst_status", status_word, 32'h0);
    chk("rst_result", result_word, 32'h0);
    chk1("rst_valid", cmd_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rst_n = 1;
    tick();
    mon_en = 1;
    tick();

    // Reset while waiting for a response.
    req = 1;
    hps_cmd_word = {1'b1, 4'd1, 27'h55};
    m_op = 4'd1; m_pl = 27'h55;
    tick(); tick();
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    tick(); tick();
    chk1("wait_busy", busy, 1'b1);
    chk1("wait_novalid", cmd_valid, 1'b0);
    mon_en = 0;
    #2 rst_n = 0;
    #1;
    chk("rstw_status", status_word, 32'h0);
    chk("rstw_result", result_word, 32'h0);
    chk1("rstw_busy", busy, 1'b0);
    hps_cmd_word = '0;
    req = 0;
    model_reset();
    tick();
    chk("rstw_opcode", 32'(cmd_opcode), 32'h0);
    chk("rstw_payload", 32'(cmd_payload), 32'h0);
    rst_n = 1;
    tick();
    mon_en = 1;
    tick();

    // Basic command, response 3 cycles after accept.
    run_cmd(4'd2, 27'h123, 0, 3, 32'hCAFE_BABE, 0, 0, 0);
    chk("t2_status", status_word, 32'h8100_8000);
    chk("t2_result", result_word, 32'hCAFE_BABE);

    // Backpressure 5 cycles, spurious rsp in ISSUE, error response.
    run_cmd(4'd5, 27'h3AB_CDEF, 5, 2, 32'h1234_5678, 1, 1, 0);
    chki("t3_valid6", vcnt, 6);
    chk("t3_status", status_word, 32'h0A81_0000);

    // Illegal opcode.
    run_cmd(4'd15, 27'h1, 0, 1, 32'h7777_7777, 0, 0, 0);
    chk("t4_status", status_word, 32'h9781_8000);
    chk("t4_result", result_word, 32'h1234_5678);

    // Timeout in WAIT; then response on the expiry cycle.
    run_cmd(4'd3, 27'h0, 0, 0, 32'h0, 0, 0, 0);
    chk("t5_status", status_word, 32'h2182_0000);
    chk("t5_result", result_word, 32'hFFFF_FFFF);
    run_cmd(4'd6, 27'h4, 0, 15, 32'hA5A5_0F0F, 0, 0, 0);
    chk("t5b_status", status_word, 32'h8302_8000);
    chk("t5b_result", result_word, 32'hA5A5_0F0F);

    // Abort in ISSUE; accept at last cycle; response after expiry.
    run_cmd(4'd1, 27'h9, 15, 0, 32'h0, 0, 0, 0);
    chki("t5c_valid15", vcnt, 15);
    run_cmd(4'd7, 27'h5, 14, 1, 32'h0101_0202, 0, 0, 0);
    run_cmd(4'd0, 27'h6, 0, 16, 32'h0303_0404, 0, 0, 0);

    // REQ toggled twice while busy: nothing extra issued.
    run_cmd(4'd4, 27'h42, 0, 6, 32'h600D_F00D, 0, 0, 1);
    vcnt = 0;
    repeat (8) tick();
    chki("t6_no_extra", vcnt, 0);
    chk1("t6_idle", busy, 1'b0);

    // Transaction count wrap.
    for (int i = 0; i < 300 && m_cnt != 8'hFF; i++)
      run_cmd(m_cnt[3:0], 27'(i), 0, 1, 32'(i * 7), 0, 0, 0);
    chk("cnt_255", 32'(status_word[22:15]), 32'hFF);
    run_cmd(4'd2, 27'h77, 0, 1, 32'hBEEF_0001, 0, 0, 0);
    chk("cnt_wrap", 32'(status_word[22:15]), 32'h0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
